intra_mb_sequencer: RTL and testbench
=====================================

Name: intra_mb_sequencer

Overview:
- Frame-level controller for the intra reconstruction datapath.
- Walks macroblock numbers 0..N-1 in raster order and accepts one residue/mode token per macroblock from the transform stage.
- Holds the datapath's enable, mbnumber and mode stable for the fixed reconstruction latency, then presents a completion token downstream.
- Sits between the inverse-transform output and the reconstruction block; the only thing it shares is the single reconstruction datapath.

Parameters:
- LENGTH, 1280, frame width in pixels.
- WIDTH, 720, frame height in pixels.
- MB_SIZE_L, 4, macroblock dimension along LENGTH.
- MB_SIZE_W, 4, macroblock dimension along WIDTH.
- RECON_LATENCY, 2, cycles recon_enable is held per macroblock (>=1).
- MBW, 16, width of macroblock counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame when idle.
- res_valid  in  1  residue/mode token available.
- res_ready  out  1  sequencer accepts token this cycle.
- res_mode  in  3  prediction mode for the current macroblock.
- recon_enable  out  1  datapath enable.
- recon_mbnumber  out  13  macroblock index to datapath (low 13 bits of the counter).
- recon_mode  out  3  mode to datapath.
- out_valid  out  1  macroblock reconstructed.
- out_ready  in  1  downstream accepts completion.
- out_mbnumber  out  MBW  index of the completed macroblock.
- mode_err  out  1  one-cycle pulse: illegal mode substituted.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last macroblock is accepted downstream.

Behaviour:
- Derived constants:
  - N = (LENGTH/MB_SIZE_L)*(WIDTH/MB_SIZE_W); N=57600 at defaults.
  - MAXMODE = 7 if MB_SIZE_L==4, else 2.
- Reset (synchronous, active-high):
  - State goes to IDLE and all outputs go to 0, including mb counter, latency counter, recon_mode and out_mbnumber.
  - Reset wins over every other input in the same cycle.
  - Reset mid-frame abandons the frame; no frame_done is generated.
- IDLE: res_ready=0.
  - start=1 clears the mb counter to 0 and moves to FETCH.
  - start while not in IDLE is ignored.
- FETCH: res_ready=1.
  - A transfer happens when res_valid && res_ready.
  - On transfer, latch recon_mode = res_mode if res_mode<=MAXMODE. Otherwise latch 0 and pulse mode_err the following cycle.
  - On transfer, load the latency counter with RECON_LATENCY-1 and go to RUN.
- RUN:
  - recon_enable=1; recon_mbnumber and recon_mode are held stable.
  - Decrement the latency counter each cycle; when it reaches 0 (the counter read 0 in this cycle), go to OUTPUT.
  - recon_enable is high for exactly RECON_LATENCY consecutive cycles per macroblock.
- OUTPUT:
  - recon_enable=0; out_valid=1; out_mbnumber = current counter.
  - out_mbnumber must not change while out_valid && !out_ready.
  - On out_ready: if counter==N-1, pulse frame_done, clear the counter and go to IDLE. Otherwise increment the counter and go to FETCH.
  - out_valid drops the cycle after acceptance.
- Throughput: minimum 1 + RECON_LATENCY + 1 cycles per macroblock when res_valid and out_ready are tied high.
  - res_ready is low in RUN and OUTPUT; no token is accepted early.
- Counter:
  - recon_mbnumber truncates the counter to 13 bits; the counter itself never wraps within a frame.
  - Wrap to 0 happens only at the end of a frame.
- busy=1 from the cycle after start is accepted until the cycle frame_done is asserted, inclusive.
- The only visible pre-start effect is res_ready=0 in IDLE; no response is generated before start.

Test Plan:
1. Small frame, 3-cycle token gap:
   - Stimulus: LENGTH=16, WIDTH=8, 4x4 (N=8), RECON_LATENCY=2, res_valid and out_ready held 1; start pulsed at cycle 0.
   - Required: 8 out_valid handshakes with out_mbnumber 0..7 in order; recon_enable high for 2 cycles each; frame_done a single pulse, one cycle after out_mbnumber=7 is accepted; busy returns to 0.
2. Mode legality:
   - Stimulus: res_mode=5 with MB_SIZE_L=4.
   - Required: recon_mode=5, no mode_err.
   - Stimulus: res_mode=5 with MB_SIZE_L=8 (MAXMODE=2).
   - Required: recon_mode=0, mode_err pulses once.
3. Backpressure:
   - Stimulus: out_ready held 0 for 10 cycles at macroblock 3.
   - Required: out_valid=1 and out_mbnumber=3 stable throughout; res_ready=0; recon_enable=0; progress resumes on the first out_ready=1.
4. Source stall:
   - Stimulus: res_valid=0 for 5 cycles in FETCH.
   - Required: res_ready stays 1, recon_enable stays 0, counter unchanged.
5. Reset mid-frame:
   - Stimulus: reset asserted in RUN at macroblock 4.
   - Required: all outputs 0 on the next edge; no frame_done; a new start restarts at out_mbnumber 0.
6. start ignored while busy:
   - Stimulus: start pulsed during macroblock 2.
   - Required: sequence unaffected; exactly one frame_done for the frame.

Source files
------------

// File: rtl/intra_mb_sequencer_if.sv
// Handshake and status bundle between the intra reconstruction sequencer and its neighbours.
// The sequencer uses the slave modport. The stage that drives start, the tokens and out_ready uses the master modport.
interface intra_mb_sequencer_if #(
    parameter int MBW = 16
);
    logic           start;
    logic           res_valid;
    logic           res_ready;
    logic [2:0]     res_mode;
    logic           recon_enable;
    logic [12:0]    recon_mbnumber;
    logic [2:0]     recon_mode;
    logic           out_valid;
    logic           out_ready;
    logic [MBW-1:0] out_mbnumber;
    logic           mode_err;
    logic           busy;
    logic           frame_done;

    modport master (
        output start, res_valid, res_mode, out_ready,
        input  res_ready, recon_enable, recon_mbnumber, recon_mode,
               out_valid, out_mbnumber, mode_err, busy, frame_done
    );

    modport slave (
        input  start, res_valid, res_mode, out_ready,
        output res_ready, recon_enable, recon_mbnumber, recon_mode,
               out_valid, out_mbnumber, mode_err, busy, frame_done
    );
endinterface

// File: rtl/intra_mb_sequencer.sv
// Frame-level sequencer: walks macroblocks in raster order, one token each.
// Each token drives the shared reconstruction datapath for a fixed latency, then a completion is presented downstream.
//
// state  | meaning
// IDLE   | waiting for start, res_ready low
// FETCH  | accepting the next residue/mode token
// RUN    | recon_enable high, latency counter running down
// OUTPUT | completion offered downstream, held until out_ready
module intra_mb_sequencer #(
    parameter int LENGTH        = 1280,
    parameter int WIDTH         = 720,
    parameter int MB_SIZE_L     = 4,
    parameter int MB_SIZE_W     = 4,
    parameter int RECON_LATENCY = 2,
    parameter int MBW           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    intra_mb_sequencer_if.slave  bus
);
    localparam int N       = (LENGTH / MB_SIZE_L) * (WIDTH / MB_SIZE_W);
    localparam int MAXMODE = (MB_SIZE_L == 4) ? 7 : 2;
    localparam int LATW    = (RECON_LATENCY > 1) ? $clog2(RECON_LATENCY) : 1;

    localparam logic [LATW-1:0] LAT_LOAD = LATW'(RECON_LATENCY - 1);
    localparam logic [MBW-1:0]  LAST_MB  = MBW'(N - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [MBW-1:0]  mb_q, mb_d;
    logic [LATW-1:0] lat_q, lat_d;
    logic [2:0]      mode_q, mode_d;
    logic            mode_err_q, mode_err_d;
    logic            done_q, done_d;

    always_comb begin
        state_d    = state_q;
        mb_d       = mb_q;
        lat_d      = lat_q;
        mode_d     = mode_q;
        mode_err_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mb_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.res_valid) begin
                    lat_d   = LAT_LOAD;
                    state_d = RUN;
                    // Illegal modes fall back to mode 0 so the datapath never sees them.
                    if (int'(bus.res_mode) > MAXMODE) begin
                        mode_d     = '0;
                        mode_err_d = 1'b1;
                    end else begin
                        mode_d = bus.res_mode;
                    end
                end
            end
            RUN: begin
                if (lat_q == '0) begin
                    state_d = OUTPUT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    if (mb_q == LAST_MB) begin
                        done_d  = 1'b1;
                        mb_d    = '0;
                        state_d = IDLE;
                    end else begin
                        mb_d    = mb_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mb_q       <= '0;
            lat_q      <= '0;
            mode_q     <= '0;
            mode_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mb_q       <= mb_d;
            lat_q      <= lat_d;
            mode_q     <= mode_d;
            mode_err_q <= mode_err_d;
            done_q     <= done_d;
        end
    end

    assign bus.res_ready      = (state_q == FETCH);
    assign bus.recon_enable   = (state_q == RUN);
    assign bus.recon_mbnumber = mb_q[12:0];
    assign bus.recon_mode     = mode_q;
    assign bus.out_valid      = (state_q == OUTPUT);
    assign bus.out_mbnumber   = mb_q;
    assign bus.mode_err       = mode_err_q;
    assign bus.frame_done     = done_q;
    // The frame_done cycle is already IDLE but still counts as busy.
    assign bus.busy           = (state_q != IDLE) | done_q;
endmodule

// File: tb/tb_intra_mb_sequencer.sv
// Bench for intra_mb_sequencer: a transaction-level model of the 4x4 frame (N=8).
// A second instance with 8-wide macroblocks exercises illegal-mode substitution.
module tb_intra_mb_sequencer;
    localparam int LAT   = 2;
    localparam int N_A   = 8;
    localparam int MAX_A = 7;
    localparam int MAX_M = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_m;

    intra_mb_sequencer_if #(.MBW(16)) a_if ();
    intra_mb_sequencer_if #(.MBW(16)) m_if ();

    intra_mb_sequencer #(
        .LENGTH(16), .WIDTH(8), .MB_SIZE_L(4), .MB_SIZE_W(4),
        .RECON_LATENCY(LAT), .MBW(16)
    ) dut_a (.clk(clk), .reset(reset_a), .bus(a_if.slave));

    intra_mb_sequencer #(
        .LENGTH(32), .WIDTH(8), .MB_SIZE_L(8), .MB_SIZE_W(4),
        .RECON_LATENCY(LAT), .MBW(16)
    ) dut_m (.clk(clk), .reset(reset_m), .bus(m_if.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model state describes the cycle the next step will drive.
    bit         m_active, m_pending, m_done, m_err, m_rst_chk;
    int         m_en, m_mb;
    logic [2:0] m_mode;
    bit         o_fd;
    int         fd_cnt = 0;
    bit         m_fin = 0;

    task automatic step(input bit st, input bit rv, input logic [2:0] md,
                        input bit ordy, input bit rst);
        bit nd, ne;
        int mdi;
        @(posedge clk);
        #1;
        a_if.start     = st;
        a_if.res_valid = rv;
        a_if.res_mode  = md;
        a_if.out_ready = ordy;
        reset_a        = rst;

        chk("res_ready",    32'(a_if.res_ready),    32'(m_active && !m_pending));
        chk("recon_enable", 32'(a_if.recon_enable), 32'(m_pending && m_en < LAT));
        chk("out_valid",    32'(a_if.out_valid),    32'(m_pending && m_en == LAT));
        chk("busy",         32'(a_if.busy),         32'(m_active || m_done));
        chk("frame_done",   32'(a_if.frame_done),   32'(m_done));
        chk("mode_err",     32'(a_if.mode_err),     32'(m_err));
        if (m_pending && m_en < LAT) begin
            chk("recon_mbnumber", 32'(a_if.recon_mbnumber), 32'(m_mb[12:0]));
            chk("recon_mode",     32'(a_if.recon_mode),     32'(m_mode));
        end
        if (m_pending && m_en == LAT)
            chk("out_mbnumber", 32'(a_if.out_mbnumber), m_mb);
        if (m_rst_chk) begin
            chk("rst_recon_mode",   32'(a_if.recon_mode),     0);
            chk("rst_out_mbnumber", 32'(a_if.out_mbnumber),   0);
            chk("rst_recon_mbnum",  32'(a_if.recon_mbnumber), 0);
        end
        o_fd = a_if.frame_done;
        if (o_fd) fd_cnt++;

        if (rst) begin
            m_active = 0; m_pending = 0; m_en = 0; m_mb = 0; m_mode = '0;
            m_done = 0; m_err = 0; m_rst_chk = 1;
        end else begin
            m_rst_chk = 0; nd = 0; ne = 0;
            mdi = int'(md);
            if (!m_active) begin
                if (st) begin m_active = 1; m_mb = 0; end
            end else if (!m_pending) begin
                if (rv) begin
                    m_pending = 1; m_en = 0;
                    m_mode = (mdi > MAX_A) ? 3'd0 : md;
                    ne = (mdi > MAX_A);
                end
            end else if (m_en < LAT) begin
                m_en++;
            end else if (ordy) begin
                m_pending = 0;
                if (m_mb == N_A - 1) begin nd = 1; m_active = 0; m_mb = 0; end
                else m_mb++;
            end
            m_done = nd; m_err = ne;
        end
    endtask

    // pol 0: free-running plus a stray start; pol 1: backpressure and stall; else random.
    task automatic run_frame(input int pol, output int cyc);
        int  fd0, bp, stl;
        bit  inj, st, rv, ordy;
        fd0 = fd_cnt; bp = 0; stl = 0; inj = 0; cyc = 0;
        step(1, 0, 3'd0, 0, 0);
        o_fd = 0;
        while (!o_fd && cyc < 2000) begin
            st = 0; rv = 1; ordy = 1;
            case (pol)
                0: if (!inj && m_mb == 2 && m_pending) begin st = 1; inj = 1; end
                1: begin
                    if (m_pending && m_en == LAT && m_mb == 3 && bp < 10) begin ordy = 0; bp++; end
                    if (m_active && !m_pending && m_mb == 5 && stl < 5) begin rv = 0; stl++; end
                end
                default: begin
                    rv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 2) != 0);
                    st   = ($urandom_range(0, 9) == 0);
                end
            endcase
            step(st, rv, 3'($urandom_range(0, 7)), ordy, 0);
            cyc++;
        end
        chk("frame_reached_done", 32'(o_fd), 1);
        chk("frame_done_count", fd_cnt - fd0, 1);
    endtask

    initial begin
        int  cyc, fd0, guard;
        bit  found;
        reset_a = 1'b1;
        a_if.start = 0; a_if.res_valid = 0; a_if.res_mode = '0; a_if.out_ready = 0;
        m_active = 0; m_pending = 0; m_en = 0; m_mb = 0; m_mode = '0;
        m_done = 0; m_err = 0; m_rst_chk = 0;
        repeat (3) step(0, 0, 3'd0, 0, 1);

        run_frame(0, cyc);
        chk("frame_cycles_free", cyc, 1 + N_A * (LAT + 2));
        run_frame(1, cyc);
        chk("frame_cycles_bp_stall", cyc, 1 + N_A * (LAT + 2) + 10 + 5);

        step(1, 0, 3'd0, 0, 0);
        found = 0; guard = 0;
        while (!found && guard < 100) begin
            step(0, 1, 3'($urandom_range(0, 7)), 1, 0);
            found = m_pending && m_en < LAT && m_mb == 4;
            guard++;
        end
        chk("reach_run_mb4", 32'(found), 1);
        fd0 = fd_cnt;
        step(0, 1, 3'd0, 1, 1);
        repeat (20) step(0, 1, 3'd0, 1, 0);
        chk("no_done_after_reset", fd_cnt - fd0, 0);
        run_frame(0, cyc);
        chk("frame_cycles_restart", cyc, 1 + N_A * (LAT + 2));

        repeat (4) run_frame(2, cyc);

        guard = 0;
        while (!m_fin && guard < 5000) begin @(posedge clk); guard++; end
        chk("mode_bench_finished", 32'(m_fin), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Instance with MAXMODE=2: first token carries mode 5, the rest are random.
    initial begin
        int  tok, n_illegal, n_err, guard, mdi;
        bit  prev_ill, seen_done, first_seen;
        logic [2:0] exp_mode, md;
        tok = 0; n_illegal = 0; n_err = 0; prev_ill = 0; seen_done = 0;
        first_seen = 0; exp_mode = '0;
        reset_m = 1'b1;
        m_if.start = 0; m_if.res_valid = 0; m_if.res_mode = '0; m_if.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_m = 1'b0; m_if.start = 1;
        @(posedge clk);
        #1;
        m_if.start = 0; m_if.res_valid = 1; m_if.out_ready = 1;
        guard = 0;
        while (!seen_done && guard < 300) begin
            chk("m_mode_err", 32'(m_if.mode_err), 32'(prev_ill));
            if (m_if.mode_err) n_err++;
            if (m_if.recon_enable) begin
                chk("m_recon_mode", 32'(m_if.recon_mode), 32'(exp_mode));
                if (!first_seen) begin
                    chk("m_first_mode5_sub", 32'(m_if.recon_mode), 0);
                    first_seen = 1;
                end
            end
            seen_done = m_if.frame_done;
            md = (tok == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            m_if.res_mode = md;
            prev_ill = 0;
            if (m_if.res_ready && m_if.res_valid) begin
                mdi = int'(md);
                prev_ill = (mdi > MAX_M);
                exp_mode = prev_ill ? 3'd0 : md;
                if (prev_ill) n_illegal++;
                tok++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        chk("m_frame_done", 32'(seen_done), 1);
        chk("m_err_pulses", n_err, n_illegal);
        chk("m_tokens", tok, 8);
        m_fin = 1;
    end
endmodule
